// File: rtl/serial_word_feeder.sv
// serial_word_feeder: valid/ready word serializer driving a bit-serial detector input
module serial_word_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             bit_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             last_bit,
  output logic             busy,
  output logic [15:0]      words_sent
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]       state;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]    bits_left;
  logic             step, consume_last, xfer;
  // All outputs decode flops only; din_ready alone looks at bit_en so a new word can chain in with no gap.
  always_comb begin
    step         = state == SHIFT && bit_en;
    last_bit     = state == SHIFT && bits_left == BW'(1);
    consume_last = step && bits_left == BW'(1);
    din_ready    = rst && (state == IDLE || consume_last);
    xfer         = din_valid && din_ready;
    ser_valid    = state == SHIFT;
    busy         = ser_valid;
    ser_out      = ser_valid ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : IDLE_BIT;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sr         <= '0;
      bits_left  <= '0;
      words_sent <= '0;
    end else begin
      if (xfer) begin
        state     <= SHIFT;
        sr        <= din;
        bits_left <= BW'(WIDTH);
      end else if (consume_last) begin
        state     <= IDLE;
        sr        <= '0;
        bits_left <= '0;
      end else if (step) begin
        sr        <= MSB_FIRST ? sr << 1 : sr >> 1;
        bits_left <= bits_left - BW'(1);
      end
      if (consume_last) words_sent <= words_sent + 16'd1;
    end
  end
endmodule

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder: directed checks of MSB-first and LSB-first/idle-high feeders
module tb_serial_word_feeder;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] din = '0, din1 = '0;
  logic dv = 1'b0, dv1 = 1'b0, be = 1'b1, be1 = 1'b1;
  logic rdy, so, sv, lb, bz, rdy1, so1, sv1, lb1, bz1;
  logic [15:0] ws, ws1;
  int vectors = 0, miscompares = 0;
  logic [7:0] w;

  always #5 clk = ~clk;

  serial_word_feeder u0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(dv), .din_ready(rdy), .bit_en(be),
    .ser_out(so), .ser_valid(sv), .last_bit(lb), .busy(bz), .words_sent(ws)
  );
  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .din_ready(rdy1), .bit_en(be1),
    .ser_out(so1), .ser_valid(sv1), .last_bit(lb1), .busy(bz1), .words_sent(ws1)
  );

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_ser_out", so, 0);
    chk("rst_ser_valid", sv, 0);
    chk("rst_last_bit", lb, 0);
    chk("rst_busy", bz, 0);
    chk("rst_words", ws, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_ser_out1", so1, 1);
    tick;
    rst = 1'b1;
    #1;
    chk("idle_ready", rdy, 1);

    // single word A0, MSB first
    w = 8'hA0; din = w; dv = 1'b1;
    tick;
    dv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("single_bit", so, w[7-i]);
      chk("single_valid", sv, 1);
      chk("single_last", lb, i == 7);
      tick;
    end
    chk("single_after_valid", sv, 0);
    chk("single_after_out", so, 0);
    chk("single_words", ws, 1);

    // back-to-back AA then 55
    din = 8'hAA; dv = 1'b1;
    tick;
    for (int i = 0; i < 16; i++) begin
      w = i < 8 ? 8'hAA : 8'h55;
      chk("b2b_bit", so, w[7-(i%8)]);
      chk("b2b_valid", sv, 1);
      chk("b2b_ready", rdy, i == 7 || i == 15);
      if (i == 7) din = 8'h55;
      if (i == 15) dv = 1'b0;
      tick;
    end
    chk("b2b_after_valid", sv, 0);
    chk("b2b_words", ws, 3);

    // throttled F0 with a pending 0F held valid throughout
    din = 8'hF0; dv = 1'b1; be = 1'b0;
    tick;
    din = 8'h0F;
    w = 8'hF0;
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < 3; c++) begin
        be = c == 2;
        #1;
        chk("thr_bit", so, w[7-b]);
        chk("thr_ready", rdy, b == 7 && c == 2);
        tick;
      end
    end
    chk("thr_next_valid", sv, 1);
    chk("thr_next_bit", so, 0);
    chk("thr_words", ws, 4);
    dv = 1'b0; be = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("thr_0f_bit", so, w[i]);
      tick;
    end
    chk("thr_drain_valid", sv, 0);
    chk("thr_drain_words", ws, 5);

    // LSB first, idle high
    chk("lsb_idle_before", so1, 1);
    w = 8'h05; din1 = w; dv1 = 1'b1;
    tick;
    dv1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_bit", so1, w[i]);
      chk("lsb_valid", sv1, 1);
      chk("lsb_last", lb1, i == 7);
      tick;
    end
    chk("lsb_idle_after", so1, 1);
    chk("lsb_after_valid", sv1, 0);
    chk("lsb_words", ws1, 1);

    // reset mid-word
    din = 8'hA5; dv = 1'b1;
    tick;
    dv = 1'b0;
    tick; tick; tick;
    chk("mid_valid", sv, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("mrst_ser_out", so, 0);
    chk("mrst_valid", sv, 0);
    chk("mrst_last", lb, 0);
    chk("mrst_busy", bz, 0);
    chk("mrst_words", ws, 0);
    chk("mrst_ready", rdy, 0);
    chk("mrst_words1", ws1, 0);
    chk("mrst_ser_out1", so1, 1);
    tick;
    rst = 1'b1;
    w = 8'h3C; din = w; dv = 1'b1;
    tick;
    dv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("post_bit", so, w[7-i]);
      chk("post_last", lb, i == 7);
      tick;
    end
    chk("post_valid", sv, 0);
    chk("post_words", ws, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
